// File: rtl/minibyte_pkg.sv
// Shared widths, loader state encoding and default I/O addresses for the Minibyte bus responder.
package minibyte_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] TICK_ADDR_DFLT = 7'h40;
  localparam logic [ADDR_W-1:0] PORT_ADDR_DFLT = 7'h41;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/minibyte_bus_loader_fsm.sv
// Byte-stream preload sequencer: one RAM write per accepted byte, no latency beyond the store edge.
// Holds ready high for the whole LOAD state; an idle valid simply stalls the sequence indefinitely.
module minibyte_bus_loader_fsm
  import minibyte_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int PTR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_halt,
  output logic              o_loading,
  output logic              o_wr_en,
  output logic [PTR_W-1:0]  o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  ld_state_e        r_state;
  ld_state_e        w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= LD_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_halt      = 1'b0;
    o_wr_en     = 1'b0;
    case (r_state)
      LD_IDLE: begin
        if (i_start) begin
          w_state_nxt = LD_LOAD;
          w_ptr_nxt   = '0;
        end
      end
      LD_LOAD: begin
        o_ready = 1'b1;
        o_halt  = 1'b1;
        if (i_valid) begin
          o_wr_en = 1'b1;
          if (r_ptr == LAST_PTR) begin
            w_state_nxt = LD_DONE;
          end else begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
          end
        end
      end
      LD_DONE: begin
        o_done      = 1'b1;
        o_halt      = 1'b1;
        w_state_nxt = LD_IDLE;
      end
      default: w_state_nxt = LD_IDLE;
    endcase
  end

  assign o_loading = (r_state != LD_IDLE);
  assign o_wr_addr = r_ptr;
  assign o_wr_data = i_data;

endmodule

// File: rtl/minibyte_bus_responder.sv
// Minibyte memory-side responder: flop RAM, tick counter and port register; 0-cycle reads, writes land next edge.
// No bus backpressure; while the preloader runs the CPU is halted and its accesses are ignored.
module minibyte_bus_responder
  import minibyte_pkg::*;
#(
  parameter int                DEPTH     = 64,
  parameter logic [ADDR_W-1:0] TICK_ADDR = TICK_ADDR_DFLT,
  parameter logic [ADDR_W-1:0] PORT_ADDR = PORT_ADDR_DFLT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              we_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              drive_out,
  output logic              cpu_halt_out,
  output logic [DATA_W-1:0] port_out,
  input  logic              ld_start_in,
  input  logic              ld_valid_in,
  input  logic [DATA_W-1:0] ld_data_in,
  output logic              ld_ready_out,
  output logic              ld_done_out
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_ram [DEPTH];
  logic [DATA_W-1:0] r_tick;
  logic [DATA_W-1:0] r_port;

  logic              w_hit_ram;
  logic              w_hit_tick;
  logic              w_hit_port;
  logic              w_loading;
  logic              w_cpu_wr;
  logic              w_ld_wr_en;
  logic [PTR_W-1:0]  w_ld_wr_addr;
  logic [DATA_W-1:0] w_ld_wr_data;
  logic [PTR_W-1:0]  w_ram_idx;

  minibyte_bus_loader_fsm #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_loader (
    .i_clk     (clk_in),
    .i_rst     (rst_in),
    .i_start   (ld_start_in),
    .i_valid   (ld_valid_in),
    .i_data    (ld_data_in),
    .o_ready   (ld_ready_out),
    .o_done    (ld_done_out),
    .o_halt    (cpu_halt_out),
    .o_loading (w_loading),
    .o_wr_en   (w_ld_wr_en),
    .o_wr_addr (w_ld_wr_addr),
    .o_wr_data (w_ld_wr_data)
  );

  assign w_hit_ram  = (addr_in < ADDR_W'(DEPTH));
  assign w_hit_tick = (addr_in == TICK_ADDR);
  assign w_hit_port = (addr_in == PORT_ADDR);
  assign w_ram_idx  = addr_in[PTR_W-1:0];
  assign w_cpu_wr   = we_in & ~w_loading;

  // Loader writes only happen while loading, so they never collide with a CPU write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ram[i] <= '0;
      end
    end else if (w_ld_wr_en) begin
      r_ram[w_ld_wr_addr] <= w_ld_wr_data;
    end else if (w_cpu_wr && w_hit_ram) begin
      r_ram[w_ram_idx] <= wdata_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tick <= '0;
      r_port <= '0;
    end else begin
      r_tick <= r_tick + DATA_W'(1);
      if (w_cpu_wr && w_hit_port) begin
        r_port <= wdata_in;
      end
    end
  end

  always_comb begin
    rdata_out = '0;
    if (!w_loading) begin
      if (w_hit_ram) begin
        rdata_out = r_ram[w_ram_idx];
      end else if (w_hit_tick) begin
        rdata_out = r_tick;
      end else if (w_hit_port) begin
        rdata_out = r_port;
      end
    end
  end

  assign drive_out = (w_hit_ram | w_hit_tick | w_hit_port) & ~we_in & ~w_loading;
  assign port_out  = r_port;

endmodule

// File: tb/tb_minibyte_bus_responder.sv
// Directed bench for minibyte_bus_responder: stimulus queues expected outputs, a negedge monitor compares them.
module tb_minibyte_bus_responder;

  localparam int DEPTH = 64;

  localparam int S_RD   = 0;
  localparam int S_DRV  = 1;
  localparam int S_HALT = 2;
  localparam int S_PORT = 3;
  localparam int S_RDY  = 4;
  localparam int S_DONE = 5;
  localparam int S_DCNT = 6;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [6:0] addr_in = 7'h50;
  logic       we_in = 1'b0;
  logic [7:0] wdata_in = 8'h00;
  logic       ld_start_in = 1'b0;
  logic       ld_valid_in = 1'b0;
  logic [7:0] ld_data_in = 8'h00;
  logic [7:0] rdata_out;
  logic       drive_out;
  logic       cpu_halt_out;
  logic [7:0] port_out;
  logic       ld_ready_out;
  logic       ld_done_out;

  minibyte_bus_responder #(.DEPTH(DEPTH)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .addr_in      (addr_in),
    .we_in        (we_in),
    .wdata_in     (wdata_in),
    .rdata_out    (rdata_out),
    .drive_out    (drive_out),
    .cpu_halt_out (cpu_halt_out),
    .port_out     (port_out),
    .ld_start_in  (ld_start_in),
    .ld_valid_in  (ld_valid_in),
    .ld_data_in   (ld_data_in),
    .ld_ready_out (ld_ready_out),
    .ld_done_out  (ld_done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  logic [7:0] tb_tick;

  // Reference tick: free-running since the last reset release.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) tb_tick <= 8'h00;
    else        tb_tick <= tb_tick + 8'h01;
  end

  always @(negedge clk_in) begin
    if (ld_done_out) done_cnt++;
  end

  always @(negedge clk_in) begin
    chk_t        c;
    logic [31:0] act;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.sel)
        S_RD:    act = 32'(rdata_out);
        S_DRV:   act = 32'(drive_out);
        S_HALT:  act = 32'(cpu_halt_out);
        S_PORT:  act = 32'(port_out);
        S_RDY:   act = 32'(ld_ready_out);
        S_DONE:  act = 32'(ld_done_out);
        S_DCNT:  act = 32'(done_cnt);
        default: act = 'x;
      endcase
      n_cmp++;
      if (act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", c.name, act, c.exp, $time);
      end
    end
  end

  task automatic push(input string n, input int s, input logic [31:0] e);
    q.push_back('{n, s, e});
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    addr_in  = a;
    we_in    = 1'b1;
    wdata_in = d;
    push("wr_drive_low", S_DRV, 0);
    cyc();
    we_in = 1'b0;
  endtask

  task automatic rd(input string n, input logic [6:0] a, input logic [7:0] e, input logic drv);
    addr_in = a;
    we_in   = 1'b0;
    push(n, S_RD, 32'(e));
    push({n, "_drive"}, S_DRV, 32'(drv));
    cyc();
  endtask

  // Starts a load and feeds nbytes with random valid gaps; the CPU pokes 0x02 throughout.
  task automatic load(input int nbytes, input logic [7:0] key);
    int idx;
    int guard;
    idx   = 0;
    guard = 0;
    ld_start_in = 1'b1;
    cyc();
    ld_start_in = 1'b0;
    while (idx < nbytes && guard < 2000) begin
      ld_valid_in = ($urandom_range(0, 2) != 0);
      ld_data_in  = 8'(idx) ^ key;
      we_in       = guard[0];
      addr_in     = 7'h02;
      wdata_in    = 8'hEE;
      push("ld_halt", S_HALT, 1);
      push("ld_ready", S_RDY, 1);
      push("ld_drive", S_DRV, 0);
      push("ld_rdata", S_RD, 0);
      push("ld_done_low", S_DONE, 0);
      cyc();
      if (ld_valid_in) idx++;
      guard++;
    end
    ld_valid_in = 1'b0;
    we_in       = 1'b0;
    if (guard >= 2000) begin
      n_err++;
      $display("FAIL load_timeout: got %0d bytes expected %0d", idx, nbytes);
    end
  endtask

  task automatic check_done(input int base);
    push("done_pulse", S_DONE, 1);
    push("done_halt", S_HALT, 1);
    push("done_ready", S_RDY, 0);
    cyc();
    push("post_done_low", S_DONE, 0);
    push("post_done_halt", S_HALT, 0);
    push("done_once", S_DCNT, 32'(base + 1));
  endtask

  task automatic reset_checks();
    push("rst_rdata", S_RD, 0);
    push("rst_drive", S_DRV, 0);
    push("rst_halt", S_HALT, 0);
    push("rst_port", S_PORT, 0);
    push("rst_ready", S_RDY, 0);
    push("rst_done", S_DONE, 0);
  endtask

  initial begin
    int base;
    int w;

    // Power-on reset
    reset_checks();
    cyc();
    cyc();
    rst_in = 1'b0;
    cyc();

    // RAM write/readback and unmapped read
    wr(7'h05, 8'hA5);
    rd("ram_05", 7'h05, 8'hA5, 1'b1);
    rd("unmapped_50", 7'h50, 8'h00, 1'b0);
    wr(7'h3F, 8'h81);
    rd("ram_3f", 7'h3F, 8'h81, 1'b1);
    wr(7'h41, 8'h77);

    // Mid-run reset clears RAM, port and tick
    addr_in = 7'h50;
    rst_in  = 1'b1;
    reset_checks();
    cyc();
    rst_in  = 1'b0;
    addr_in = 7'h40;
    push("tick_restart", S_RD, 0);
    cyc();
    push("tick_one", S_RD, 1);
    cyc();
    for (int i = 0; i < DEPTH; i++) rd("rst_ram_zero", 7'(i), 8'h00, 1'b1);

    // Port register and tick
    wr(7'h41, 8'h3C);
    push("port_next", S_PORT, 32'h3C);
    rd("port_read", 7'h41, 8'h3C, 1'b1);
    wr(7'h40, 8'h99);
    rd("tick_a", 7'h40, tb_tick, 1'b1);
    rd("tick_b", 7'h40, tb_tick, 1'b1);
    addr_in = 7'h40;
    w = 0;
    while (tb_tick != 8'hFF && w < 300) begin
      cyc();
      w++;
    end
    push("tick_ff", S_RD, 32'hFF);
    cyc();
    push("tick_wrap", S_RD, 32'h00);
    cyc();

    // Full load with gaps and blocked CPU writes
    base = done_cnt;
    load(DEPTH, 8'h5A);
    check_done(base);
    push("port_kept", S_PORT, 32'h3C);
    cyc();
    for (int i = 0; i < DEPTH; i++) rd("load_readback", 7'(i), 8'(i) ^ 8'h5A, 1'b1);

    // Reset during a partial load
    load(10, 8'h5A);
    addr_in = 7'h50;
    rst_in  = 1'b1;
    push("midload_rst_halt", S_HALT, 0);
    push("midload_rst_ready", S_RDY, 0);
    push("midload_rst_done", S_DONE, 0);
    push("midload_rst_port", S_PORT, 0);
    cyc();
    rst_in = 1'b0;
    cyc();
    push("idle_after_rst", S_HALT, 0);
    for (int i = 0; i < DEPTH; i++) rd("partial_cleared", 7'(i), 8'h00, 1'b1);
    base = done_cnt;
    load(DEPTH, 8'hC3);
    check_done(base);
    cyc();
    for (int i = 0; i < DEPTH; i++) rd("reload_readback", 7'(i), 8'(i) ^ 8'hC3, 1'b1);

    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
